fetch_line_sequencer: RTL and testbench

- Sits between the instruction-cache fetch stage and decode.
- Accepts one 64-byte fetch line (16 x 32-bit instructions) plus its branch-prediction result, and trims it to the live instruction window: from the fetch PC up to and including a predicted-taken branch.
- Buffers up to DEPTH lines and issues the live instructions to decode in packed groups of up to ISSUE_WIDTH per cycle, under a valid/ready handshake.
- A redirect flush discards all buffered work.

---
 rtl/fetch_line_sequencer_pkg.sv | 33 +++
 rtl/fetch_window_calc.sv | 28 ++
 rtl/fetch_line_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_line_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_line_sequencer_pkg.sv
// Shared frontend definitions for the fetch line sequencer
// and the fetch-stage blocks that reuse its window logic.
package fetch_line_sequencer_pkg;

    localparam int INST_W     = 32;
    localparam int LINE_INSTS = 16;
    localparam int LINE_BYTES = 64;
    localparam int LINE_W     = INST_W * LINE_INSTS;
    localparam int LPC_W      = 64 - $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        ENT_EMPTY,
        ENT_QUEUED,
        ENT_ISSUING
    } ent_state_t;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [LPC_W-1:0]  linepc;
        logic [3:0]        start;
        logic [3:0]        end_idx;
        logic              taken_ok;
    } line_entry_t;

    // Instructions left from p up to and including e (1..16).
    function automatic logic [4:0] win_remain(
        input logic [3:0] e,
        input logic [3:0] p
    );
        return {1'b0, e} - {1'b0, p} + 5'd1;
    endfunction

endpackage

// File: rtl/fetch_window_calc.sv
// Live-window calculation for a fetch line: first slot from the
// fetch PC, last slot at a predicted-taken branch in the same line.
module fetch_window_calc (
    input  logic [63:0] i_base_pc,
    input  logic [63:0] i_trigger_pc,
    input  logic        i_predict_valid,
    output logic [3:0]  o_start,
    output logic [3:0]  o_end,
    output logic        o_taken_ok
);

    logic w_same_line;
    logic w_after_start;
    logic w_hit;
    logic w_unused;

    assign w_unused = ^{i_base_pc[1:0], i_trigger_pc[1:0]};

    assign o_start       = i_base_pc[5:2];
    assign w_same_line   = i_trigger_pc[63:6] == i_base_pc[63:6];
    assign w_after_start = i_trigger_pc[5:2] >= i_base_pc[5:2];
    assign w_hit         = i_predict_valid & w_same_line & w_after_start;

    // A branch before the fetch PC or in another line is ignored.
    assign o_end      = w_hit ? i_trigger_pc[5:2] : 4'd15;
    assign o_taken_ok = w_hit;

endmodule

// File: rtl/fetch_line_sequencer.sv
// Fetch line buffer that trims each line to its live window and
// issues packed instruction groups to decode.
import fetch_line_sequencer_pkg::*;

module fetch_line_sequencer #(
    parameter int ISSUE_WIDTH = 4,
    parameter int DEPTH       = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     line_valid,
    output logic                     line_ready,
    input  logic [LINE_W-1:0]        line_data,
    input  logic [63:0]              base_pc,
    input  logic                     predict_valid,
    input  logic [63:0]              trigger_pc,
    output logic [ISSUE_WIDTH-1:0]   out_valid,
    output logic [32*ISSUE_WIDTH-1:0] out_inst,
    output logic [64*ISSUE_WIDTH-1:0] out_pc,
    output logic [ISSUE_WIDTH-1:0]   out_taken,
    input  logic                     out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] IW5 = 5'(ISSUE_WIDTH);

    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_ptr;
    line_entry_t   r_mem [DEPTH];
    ent_state_t    r_st  [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_fire;
    logic          w_pop;
    logic          w_last;
    logic          w_head_live;
    logic [4:0]    w_rem;
    logic [4:0]    w_n;
    logic [3:0]    w_start;
    logic [3:0]    w_end;
    logic          w_taken_ok;
    logic [AW-1:0] w_next_rd;
    line_entry_t   w_head;
    line_entry_t   w_new;

    fetch_window_calc u_win (
        .i_base_pc       (base_pc),
        .i_trigger_pc    (trigger_pc),
        .i_predict_valid (predict_valid),
        .o_start         (w_start),
        .o_end           (w_end),
        .o_taken_ok      (w_taken_ok)
    );

    assign w_full  = r_cnt == CW'(DEPTH);
    assign w_empty = r_cnt == '0;

    assign line_ready = !w_full & !flush & !reset;
    assign w_push     = line_valid & line_ready;

    assign w_new.data     = line_data;
    assign w_new.linepc   = base_pc[63:6];
    assign w_new.start    = w_start;
    assign w_new.end_idx  = w_end;
    assign w_new.taken_ok = w_taken_ok;

    assign w_head      = r_mem[r_rd];
    assign w_head_live = !w_empty && (r_st[r_rd] != ENT_EMPTY);
    assign w_next_rd   = r_rd + 1'b1;

    assign w_rem  = win_remain(w_head.end_idx, r_ptr);
    assign w_last = w_rem <= IW5;
    assign w_n    = w_last ? w_rem : IW5;

    // Flush outranks decode acceptance in the same cycle.
    assign w_fire = w_head_live & out_ready & !flush;
    assign w_pop  = w_fire & w_last;

    // Slot outputs are a pure function of the head entry and ptr,
    // so a stalled group stays put until it is accepted.
    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
        logic [3:0] w_idx;
        logic       w_v;

        assign w_idx = r_ptr + 4'(g);
        assign w_v   = w_head_live && (5'(g) < w_n);

        assign out_valid[g] = w_v;
        assign out_inst[32*g +: 32] =
            w_v ? w_head.data[{w_idx, 5'b0} +: 32] : '0;
        assign out_pc[64*g +: 64] =
            w_v ? {w_head.linepc, w_idx, 2'b00} : '0;
        assign out_taken[g] =
            w_v & w_head.taken_ok & (w_idx == w_head.end_idx);
    end

    // Line buffer, per-entry lifecycle and issue pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]  <= ENT_EMPTY;
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i] <= ENT_EMPTY;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_new;
                r_st[r_wr]  <= ENT_QUEUED;
                r_wr        <= r_wr + 1'b1;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (AW'(i) == r_rd && r_st[i] == ENT_QUEUED) begin
                    r_st[i] <= ENT_ISSUING;
                end
            end

            if (w_pop) begin
                r_st[r_rd] <= ENT_EMPTY;
                r_rd       <= w_next_rd;
            end

            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

            // The next head is either already queued or the line
            // arriving this cycle into an otherwise empty buffer.
            if (w_pop) begin
                if (r_cnt > CW'(1)) begin
                    r_ptr <= r_mem[w_next_rd].start;
                end else if (w_push) begin
                    r_ptr <= w_start;
                end else begin
                    r_ptr <= '0;
                end
            end else if (w_fire) begin
                r_ptr <= r_ptr + w_n[3:0];
            end else if (w_empty && w_push) begin
                r_ptr <= w_start;
            end
        end
    end

endmodule

// File: tb/tb_fetch_line_sequencer.sv
// Directed bench for fetch_line_sequencer: windowing, packing,
// backpressure, flush and asynchronous reset.
module tb_fetch_line_sequencer;

    localparam int IW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              line_valid = 1'b0;
    logic              line_ready;
    logic [511:0]      line_data = '0;
    logic [63:0]       base_pc = '0;
    logic              predict_valid = 1'b0;
    logic [63:0]       trigger_pc = '0;
    logic [IW-1:0]     out_valid;
    logic [32*IW-1:0]  out_inst;
    logic [64*IW-1:0]  out_pc;
    logic [IW-1:0]     out_taken;
    logic              out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    fetch_line_sequencer #(
        .ISSUE_WIDTH (IW),
        .DEPTH       (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .line_data     (line_data),
        .base_pc       (base_pc),
        .predict_valid (predict_valid),
        .trigger_pc    (trigger_pc),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_taken     (out_taken),
        .out_ready     (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [7:0] t);
        logic [511:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) begin
            d[32*k +: 32] = {t, 24'(k)};
        end
        return d;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic offer(
        input logic [7:0]  t,
        input logic [63:0] bpc,
        input logic [63:0] tpc,
        input logic        pv
    );
        line_valid    = 1'b1;
        line_data     = mk_line(t);
        base_pc       = bpc;
        trigger_pc    = tpc;
        predict_valid = pv;
        #1;
    endtask

    task automatic push(
        input logic [7:0]  t,
        input logic [63:0] bpc,
        input logic [63:0] tpc,
        input logic        pv
    );
        offer(t, bpc, tpc, pv);
        check("push_rdy", 64'(line_ready), 64'd1);
        tick;
        line_valid = 1'b0;
    endtask

    task automatic grp(
        input string       t,
        input int          first,
        input int          cnt,
        input logic [63:0] lpc,
        input logic [7:0]  lt,
        input logic [3:0]  tk
    );
        logic [3:0]  vm;
        logic [63:0] ep;
        logic [31:0] ei;
        vm = 4'((1 << cnt) - 1);
        check({t, ".valid"}, 64'(out_valid), 64'(vm));
        check({t, ".taken"}, 64'(out_taken), 64'(tk));
        for (int i = 0; i < IW; i++) begin
            if (i < cnt) begin
                ep = lpc + 64'(4 * (first + i));
                ei = {lt, 24'(first + i)};
            end else begin
                ep = '0;
                ei = '0;
            end
            check($sformatf("%s.pc%0d", t, i), out_pc[64*i +: 64], ep);
            check($sformatf("%s.inst%0d", t, i),
                  64'(out_inst[32*i +: 32]), 64'(ei));
        end
    endtask

    task automatic zero_outs(input string t);
        check({t, ".valid"}, 64'(out_valid), 64'd0);
        check({t, ".inst"}, 64'(|out_inst), 64'd0);
        check({t, ".pc"}, 64'(|out_pc), 64'd0);
        check({t, ".taken"}, 64'(out_taken), 64'd0);
        check({t, ".rdy"}, 64'(line_ready), 64'd0);
    endtask

    initial begin
        repeat (2) tick;
        zero_outs("rst");
        reset = 1'b0;
        tick;
        check("rdy_after_rst", 64'(line_ready), 64'd1);
        check("empty_after_rst", 64'(out_valid), 64'd0);

        // Aligned line, no prediction.
        out_ready = 1'b1;
        push(8'hA1, 64'h8000_0000, 64'h0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            grp($sformatf("t1g%0d", g), 4 * g, 4,
                64'h8000_0000, 8'hA1, 4'b0000);
            tick;
        end
        check("t1_empty", 64'(out_valid), 64'd0);

        // Unaligned start with an in-line taken branch.
        push(8'hB2, 64'h1008, 64'h1020, 1'b1);
        grp("t2a", 2, 4, 64'h1000, 8'hB2, 4'b0000);
        tick;
        grp("t2b", 6, 3, 64'h1000, 8'hB2, 4'b0100);
        tick;
        check("t2_empty", 64'(out_valid), 64'd0);

        // Branch behind the fetch PC is ignored.
        push(8'hC3, 64'h1010, 64'h1004, 1'b1);
        grp("t3a", 4, 4, 64'h1000, 8'hC3, 4'b0000);
        tick;
        grp("t3b", 8, 4, 64'h1000, 8'hC3, 4'b0000);
        tick;
        grp("t3c", 12, 4, 64'h1000, 8'hC3, 4'b0000);
        tick;
        check("t3_empty", 64'(out_valid), 64'd0);

        // Backpressure, full buffer, in-order drain.
        out_ready = 1'b0;
        push(8'h11, 64'h2000, 64'h0, 1'b0);
        grp("t4l1", 0, 4, 64'h2000, 8'h11, 4'b0000);
        push(8'h22, 64'h3030, 64'h0, 1'b0);
        offer(8'h33, 64'h4000, 64'h4004, 1'b1);
        check("t4_full", 64'(line_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick;
            grp($sformatf("t4hold%0d", c), 0, 4,
                64'h2000, 8'h11, 4'b0000);
            check("t4_full_hold", 64'(line_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick;
        grp("t4l1b", 4, 4, 64'h2000, 8'h11, 4'b0000);
        check("t4_rdy_b", 64'(line_ready), 64'd0);
        tick;
        grp("t4l1c", 8, 4, 64'h2000, 8'h11, 4'b0000);
        tick;
        grp("t4l1d", 12, 4, 64'h2000, 8'h11, 4'b0000);
        check("t4_rdy_d", 64'(line_ready), 64'd0);
        tick;
        grp("t4l2", 12, 4, 64'h3000, 8'h22, 4'b0000);
        check("t4_rdy_pop", 64'(line_ready), 64'd1);
        tick;
        line_valid = 1'b0;
        grp("t4l3", 0, 2, 64'h4000, 8'h33, 4'b0010);
        tick;
        check("t4_empty", 64'(out_valid), 64'd0);

        // Flush mid-line with a second line queued.
        push(8'h55, 64'h5000, 64'h0, 1'b0);
        push(8'h66, 64'h6000, 64'h0, 1'b0);
        grp("t5a1", 4, 4, 64'h5000, 8'h55, 4'b0000);
        flush = 1'b1;
        offer(8'h77, 64'h7000, 64'h0, 1'b0);
        check("t5_rdy_flush", 64'(line_ready), 64'd0);
        tick;
        flush = 1'b0;
        line_valid = 1'b0;
        check("t5_flushed", 64'(out_valid), 64'd0);
        tick;
        check("t5_still_empty", 64'(out_valid), 64'd0);
        push(8'h99, 64'h7008, 64'h0, 1'b0);
        grp("t5d", 2, 4, 64'h7000, 8'h99, 4'b0000);

        // Asynchronous reset between clock edges.
        out_ready = 1'b0;
        tick;
        grp("t6hold", 2, 4, 64'h7000, 8'h99, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        zero_outs("t6rst");
        @(negedge clock);
        reset = 1'b0;
        tick;
        check("t6_rdy", 64'(line_ready), 64'd1);
        check("t6_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
